data_mem_responder: RTL and testbench
=====================================

Name: data_mem_responder

Overview:
Data-memory responder for the pipelined MIPS CPU. It serves the load/store requests the CPU's memory stage issues, over a request/ready handshake with a configurable wait-state count. While a transaction is in flight it asserts a busy flag so the pipeline can stall. It holds a word-organised RAM with byte-lane write enables and flags misaligned or out-of-range accesses.

Parameters:
DEPTH_WORDS, 512, number of 32-bit words in the RAM (power of two, at least 4)
WAIT_CYCLES, 2, extra wait states between request capture and response (0 to 15)
ADDR_BASE, 32'h0000_0000, byte address of word 0 (word aligned)

Ports:
CLOCK  input  1  system clock, rising-edge
RESET  input  1  asynchronous, active-low reset
MemReq  input  1  request strobe, sampled only in IDLE
MemWriteEN  input  1  1 = store, 0 = load
Addr  input  32  byte address
WriteData  input  32  store data
ByteEN  input  4  store byte lanes; bit i selects WriteData[8i+7:8i]
ReadData  output  32  load result, valid while MemReady=1
MemReady  output  1  one-cycle response pulse
MemBusy  output  1  1 whenever state is not IDLE
AddrError  output  1  qualifies MemReady; the access was rejected

Behaviour:
- Reset (RESET=0, asynchronous):
  - state=IDLE, wait counter=0.
  - ReadData=0, MemReady=0, MemBusy=0, AddrError=0.
  - All RAM words cleared to 0.
  - Captured request registers cleared.
- Address decode:
  - idx = (Addr - ADDR_BASE) >> 2.
  - Valid iff Addr[1:0]==2'b00, Addr >= ADDR_BASE and idx < DEPTH_WORDS.
  - Comparison is unsigned, 32-bit, with no wrap.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - On an edge with MemReq=1: capture Addr, WriteData, ByteEN, MemWriteEN and the valid flag.
  - Load counter=WAIT_CYCLES and go to WAIT.
  - MemReq=0: stay in IDLE.
- WAIT:
  - Each edge with counter != 0: decrement.
  - Edge with counter == 0: go to RESP, committing the access on that same edge.
  - Valid store: merge the enabled byte lanes into RAM[idx]. ByteEN=0 leaves the word unchanged but still responds.
  - ReadData is registered:
    - valid load: RAM[idx] before any change;
    - valid store: the merged word;
    - invalid access: 32'h0.
  - AddrError is set to the inverse of the captured valid flag. An invalid store never modifies RAM.
- RESP:
  - MemReady=1 for exactly one cycle; the next edge returns to IDLE.
  - On that edge MemReady and AddrError drop to 0.
  - ReadData holds its value until the next commit.
- Latency:
  - Request sampled at edge k gives MemReady high in the cycle after edge k+WAIT_CYCLES+1.
  - Minimum request-to-request spacing is WAIT_CYCLES+3 cycles.
- MemReq during WAIT or RESP is ignored (not queued). The requester must hold off while MemBusy=1.
- Input changes after capture do not affect the transaction in flight.
- Reset mid-transaction:
  - Asserted before the commit edge: the access is aborted, no RAM write, no MemReady pulse.
  - Asserted after the commit edge: RAM is cleared anyway by reset.
- Loads return the full word; ByteEN is ignored for loads.

Test Plan:
- Reset then load: release RESET, load at Addr=0x10 -> MemReady pulse 3 cycles after capture (WAIT_CYCLES=2), ReadData=0x0, AddrError=0, MemBusy high for those 3 cycles.
- Store/load round-trip: store 0xDEADBEEF at 0x20 with ByteEN=4'b1111, then load 0x20 -> ReadData=0xDEADBEEF; store response also returns 0xDEADBEEF.
- Byte lanes: after the round-trip above, store 0x000000AA with ByteEN=4'b0001, and 0x11223344 with ByteEN=4'b1000 -> load 0x20 returns 0x11ADBEAA.
- Errors:
  - load at 0x22 (misaligned) -> MemReady=1, AddrError=1, ReadData=0;
  - store at byte address DEPTH_WORDS*4 -> AddrError=1;
  - load at address 0 afterwards -> unchanged contents.
- Busy/ignore: assert MemReq continuously with changing Addr during WAIT -> only the first request is served; the next is captured on the first IDLE edge; spacing is 5 cycles.
- Reset mid-op: store 0x12345678 to 0x40, assert RESET during WAIT -> no MemReady pulse; after release, load 0x40 returns 0x0. Repeat with WAIT_CYCLES=0: MemReady asserts 1 cycle after capture.

Source files
------------

// File: rtl/data_mem_responder.sv
// Data-memory responder for the pipelined MIPS memory stage: request/ready handshake with
// programmable wait states, byte-lane stores and rejection of misaligned/out-of-range accesses.
module data_mem_responder #(
   parameter int unsigned DEPTH_WORDS = 512,
   parameter int unsigned WAIT_CYCLES = 2,
   parameter logic [31:0] ADDR_BASE   = 32'h0000_0000
) (
   input  logic        CLOCK,
   input  logic        RESET,
   input  logic        MemReq,
   input  logic        MemWriteEN,
   input  logic [31:0] Addr,
   input  logic [31:0] WriteData,
   input  logic [3:0]  ByteEN,
   output logic [31:0] ReadData,
   output logic        MemReady,
   output logic        MemBusy,
   output logic        AddrError
);

   localparam int unsigned AW = $clog2(DEPTH_WORDS);

   typedef enum logic [1:0] {StIdle, StWait, StResp} state_t;

   state_t           state_q;
   logic [3:0]       cnt_q;
   logic [AW-1:0]    cap_idx_q;
   logic [31:0]      cap_wdata_q;
   logic [3:0]       cap_be_q;
   logic             cap_we_q;
   logic             cap_valid_q;
   logic [31:0]      mem_q [DEPTH_WORDS];

   logic [32:0]      diff;
   logic             req_valid;
   logic [AW-1:0]    req_idx;
   logic [31:0]      cur_word;
   logic [31:0]      merged;

   // Bit 32 of the difference is the borrow, so addresses below the base never wrap in.
   always_comb begin
      diff      = {1'b0, Addr} - {1'b0, ADDR_BASE};
      req_valid = !diff[32] && (diff[1:0] == 2'b00) && (diff[31:AW+2] == '0);
      req_idx   = diff[AW+1:2];
   end

   always_comb begin
      cur_word = mem_q[cap_idx_q];
      merged   = cur_word;
      for (int i = 0; i < 4; i++) begin
         if (cap_be_q[i]) merged[8*i +: 8] = cap_wdata_q[8*i +: 8];
      end
   end

   always_ff @(posedge CLOCK or negedge RESET) begin
      if (!RESET) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         cap_idx_q   <= '0;
         cap_wdata_q <= '0;
         cap_be_q    <= '0;
         cap_we_q    <= 1'b0;
         cap_valid_q <= 1'b0;
         ReadData    <= '0;
         MemReady    <= 1'b0;
         MemBusy     <= 1'b0;
         AddrError   <= 1'b0;
         for (int unsigned i = 0; i < DEPTH_WORDS; i++) mem_q[i] <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (MemReq) begin
                  cap_idx_q   <= req_idx;
                  cap_wdata_q <= WriteData;
                  cap_be_q    <= ByteEN;
                  cap_we_q    <= MemWriteEN;
                  cap_valid_q <= req_valid;
                  cnt_q       <= 4'(WAIT_CYCLES);
                  MemBusy     <= 1'b1;
                  state_q     <= StWait;
               end
            end
            StWait: begin
               if (cnt_q != 4'd0) begin
                  cnt_q <= cnt_q - 4'd1;
               end else begin
                  // Commit edge: the access and the registered response happen together.
                  state_q   <= StResp;
                  MemReady  <= 1'b1;
                  AddrError <= !cap_valid_q;
                  if (cap_valid_q) begin
                     ReadData <= cap_we_q ? merged : cur_word;
                     if (cap_we_q) mem_q[cap_idx_q] <= merged;
                  end else begin
                     ReadData <= '0;
                  end
               end
            end
            StResp: begin
               state_q   <= StIdle;
               MemReady  <= 1'b0;
               AddrError <= 1'b0;
               MemBusy   <= 1'b0;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: one instance with two wait states, one with none.
module tb_data_mem_responder;

   logic        CLOCK = 1'b0;
   logic        RESET = 1'b0;
   logic        MemReq = 1'b0;
   logic        MemWriteEN = 1'b0;
   logic [31:0] Addr = '0;
   logic [31:0] WriteData = '0;
   logic [3:0]  ByteEN = '0;

   logic [31:0] rd_a, rd_b;
   logic        rdy_a, rdy_b, busy_a, busy_b, err_a, err_b;

   int checks = 0;
   int errors = 0;

   always #5 CLOCK = ~CLOCK;

   data_mem_responder #(
      .DEPTH_WORDS(512),
      .WAIT_CYCLES(2),
      .ADDR_BASE  (32'h0000_0000)
   ) dut (
      .CLOCK     (CLOCK),
      .RESET     (RESET),
      .MemReq    (MemReq),
      .MemWriteEN(MemWriteEN),
      .Addr      (Addr),
      .WriteData (WriteData),
      .ByteEN    (ByteEN),
      .ReadData  (rd_a),
      .MemReady  (rdy_a),
      .MemBusy   (busy_a),
      .AddrError (err_a)
   );

   data_mem_responder #(
      .DEPTH_WORDS(512),
      .WAIT_CYCLES(0),
      .ADDR_BASE  (32'h0000_0000)
   ) dut0 (
      .CLOCK     (CLOCK),
      .RESET     (RESET),
      .MemReq    (MemReq),
      .MemWriteEN(MemWriteEN),
      .Addr      (Addr),
      .WriteData (WriteData),
      .ByteEN    (ByteEN),
      .ReadData  (rd_b),
      .MemReady  (rdy_b),
      .MemBusy   (busy_b),
      .AddrError (err_b)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Drives one request for a single capture edge; returns at the negedge after capture.
   task automatic req(input logic we, input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] be);
      @(negedge CLOCK);
      MemReq     = 1'b1;
      MemWriteEN = we;
      Addr       = a;
      WriteData  = wd;
      ByteEN     = be;
      @(negedge CLOCK);
      MemReq     = 1'b0;
   endtask

   task automatic wait_resp(input string tag, input bit sel, input int exp_lat,
                            input logic [31:0] exp_data, input logic exp_err);
      int n = 0;
      bit seen = 0;
      logic [31:0] held;
      while (n < 20 && !seen) begin
         @(negedge CLOCK);
         n++;
         if (sel ? rdy_b : rdy_a) seen = 1;
      end
      chk({tag, " latency"}, 32'(n), 32'(exp_lat));
      chk({tag, " data"}, sel ? rd_b : rd_a, exp_data);
      chk({tag, " err"}, 32'(sel ? err_b : err_a), 32'(exp_err));
      chk({tag, " busy in resp"}, 32'(sel ? busy_b : busy_a), 32'd1);
      held = exp_data;
      @(negedge CLOCK);
      chk({tag, " ready drop"}, 32'(sel ? rdy_b : rdy_a), 32'd0);
      chk({tag, " err drop"}, 32'(sel ? err_b : err_a), 32'd0);
      chk({tag, " busy drop"}, 32'(sel ? busy_b : busy_a), 32'd0);
      chk({tag, " data hold"}, sel ? rd_b : rd_a, held);
   endtask

   initial begin
      int ready_at [2];
      int n_ready;
      bit any_ready;

      // Reset state
      #12;
      chk("rst data", rd_a, 32'h0);
      chk("rst ready", 32'(rdy_a), 32'd0);
      chk("rst busy", 32'(busy_a), 32'd0);
      chk("rst err", 32'(err_a), 32'd0);
      @(negedge CLOCK);
      RESET = 1'b1;

      // First load after reset
      req(1'b0, 32'h10, 32'h0, 4'h0);
      chk("busy after capture", 32'(busy_a), 32'd1);
      wait_resp("load 0x10", 1'b0, 3, 32'h0, 1'b0);

      // Round trip and byte lanes
      req(1'b1, 32'h20, 32'hDEAD_BEEF, 4'b1111);
      wait_resp("store full", 1'b0, 3, 32'hDEAD_BEEF, 1'b0);
      req(1'b0, 32'h20, 32'h0, 4'b1111);
      wait_resp("load full", 1'b0, 3, 32'hDEAD_BEEF, 1'b0);
      req(1'b1, 32'h20, 32'h0000_00AA, 4'b0001);
      wait_resp("store lane0", 1'b0, 3, 32'hDEAD_BEAA, 1'b0);
      req(1'b1, 32'h20, 32'h1122_3344, 4'b1000);
      wait_resp("store lane3", 1'b0, 3, 32'h11AD_BEAA, 1'b0);
      req(1'b1, 32'h20, 32'hFFFF_FFFF, 4'b0000);
      wait_resp("store no lanes", 1'b0, 3, 32'h11AD_BEAA, 1'b0);
      req(1'b0, 32'h20, 32'h0, 4'b0000);
      wait_resp("load merged", 1'b0, 3, 32'h11AD_BEAA, 1'b0);

      // Rejected accesses
      req(1'b0, 32'h22, 32'h0, 4'b1111);
      wait_resp("load misaligned", 1'b0, 3, 32'h0, 1'b1);
      req(1'b1, 32'h800, 32'hFFFF_FFFF, 4'b1111);
      wait_resp("store out of range", 1'b0, 3, 32'h0, 1'b1);
      req(1'b0, 32'h0, 32'h0, 4'b0000);
      wait_resp("load word0", 1'b0, 3, 32'h0, 1'b0);

      // MemReq held high with changing Addr: only the edge-0 and edge-5 captures are served
      n_ready = 0;
      for (int j = 0; j < 15; j++) begin
         @(negedge CLOCK);
         if (rdy_a) begin
            if (n_ready < 2) ready_at[n_ready] = j;
            n_ready++;
            if (n_ready == 2) begin
               chk("ignore second data", rd_a, 32'h11AD_BEAA);
               chk("ignore second err", 32'(err_a), 32'd0);
            end
         end
         if (j == 2) chk("ignore busy mid", 32'(busy_a), 32'd1);
         MemReq     = (j <= 5);
         MemWriteEN = 1'b0;
         Addr       = (j == 0 || j == 5) ? 32'h20 : 32'h22;
      end
      MemReq = 1'b0;
      chk("ignore count", 32'(n_ready), 32'd2);
      chk("ignore first at", 32'(ready_at[0]), 32'd4);
      chk("ignore spacing", 32'(ready_at[1] - ready_at[0]), 32'd5);
      repeat (3) @(negedge CLOCK);

      // Reset during WAIT aborts the store
      req(1'b1, 32'h40, 32'h1234_5678, 4'b1111);
      RESET = 1'b0;
      any_ready = 0;
      repeat (5) begin
         @(negedge CLOCK);
         if (rdy_a) any_ready = 1;
      end
      chk("abort busy", 32'(busy_a), 32'd0);
      RESET = 1'b1;
      repeat (5) begin
         @(negedge CLOCK);
         if (rdy_a) any_ready = 1;
      end
      chk("abort no ready", 32'(any_ready), 32'd0);
      req(1'b0, 32'h40, 32'h0, 4'b0000);
      wait_resp("load after abort", 1'b0, 3, 32'h0, 1'b0);
      req(1'b0, 32'h20, 32'h0, 4'b0000);
      wait_resp("load cleared", 1'b0, 3, 32'h0, 1'b0);
      repeat (3) @(negedge CLOCK);

      // Zero wait states
      req(1'b1, 32'h40, 32'h1234_5678, 4'b1111);
      wait_resp("w0 store", 1'b1, 1, 32'h1234_5678, 1'b0);
      repeat (4) @(negedge CLOCK);
      req(1'b0, 32'h40, 32'h0, 4'b0000);
      wait_resp("w0 load", 1'b1, 1, 32'h1234_5678, 1'b0);
      repeat (4) @(negedge CLOCK);
      req(1'b1, 32'h44, 32'hCAFE_F00D, 4'b1111);
      RESET = 1'b0;
      any_ready = 0;
      repeat (3) begin
         @(negedge CLOCK);
         if (rdy_b) any_ready = 1;
      end
      RESET = 1'b1;
      repeat (3) begin
         @(negedge CLOCK);
         if (rdy_b) any_ready = 1;
      end
      chk("w0 abort no ready", 32'(any_ready), 32'd0);
      req(1'b0, 32'h44, 32'h0, 4'b0000);
      wait_resp("w0 load after abort", 1'b1, 1, 32'h0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
